// File: rtl/data_mem_lsu.sv
// Byte-addressable little-endian data memory for the MEM stage: RV32I load/store
// widths, lane-masked stores, sign/zero-extended loads, fixed wait states, error flagging.
module data_mem_lsu #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int         WORD_BITS = ADDR_WIDTH - 2;
  localparam int         DEPTH     = 1 << WORD_BITS;
  localparam logic [3:0] WS_LOAD   = 4'(WAIT_STATES);

  // One-hot so req_ready comes straight off a flop.
  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_WAIT = 3'b010;
  localparam logic [2:0] S_RESP = 3'b100;

  logic [2:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [31:0]           mem_q [DEPTH];

  logic [WORD_BITS-1:0]  word_idx;
  logic [1:0]            lane;
  logic [31:0]           rd_word;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [31:0]           load_data;
  logic                  acc_err;
  logic [3:0]            wr_mask;
  logic [31:0]           wr_data;
  logic                  commit;

  assign req_ready = state_q[0];
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    word_idx = addr_q[ADDR_WIDTH-1:2];
    lane     = addr_q[1:0];
    rd_word  = mem_q[word_idx];
    sel_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (lane)
      2'd0:    sel_byte = rd_word[7:0];
      2'd1:    sel_byte = rd_word[15:8];
      2'd2:    sel_byte = rd_word[23:16];
      2'd3:    sel_byte = rd_word[31:24];
      default: sel_byte = 8'h00;
    endcase
  end

  // Stores only accept 000/001/010; 011/110/111 are illegal for both directions.
  always_comb begin
    acc_err = 1'b0;
    case (f3_q)
      3'b000, 3'b100: acc_err = we_q & f3_q[2];
      3'b001, 3'b101: acc_err = addr_q[0] | (we_q & f3_q[2]);
      3'b010:         acc_err = (addr_q[1:0] != 2'b00);
      default:        acc_err = 1'b1;
    endcase
  end

  always_comb begin
    load_data = 32'h0000_0000;
    wr_mask   = 4'b0000;
    wr_data   = 32'h0000_0000;
    case (f3_q)
      3'b000: begin
        load_data = {{24{sel_byte[7]}}, sel_byte};
        wr_mask   = 4'b0001 << lane;
        wr_data   = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        load_data = {{16{sel_half[15]}}, sel_half};
        wr_mask   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data   = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        load_data = rd_word;
        wr_mask   = 4'b1111;
        wr_data   = wdata_q;
      end
      3'b100:  load_data = {24'h00_0000, sel_byte};
      3'b101:  load_data = {16'h0000, sel_half};
      default: load_data = 32'h0000_0000;
    endcase
    commit = state_q[2] & we_q & ~acc_err;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WS_LOAD;
          state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = acc_err;
        rsp_rdata_d = (we_q | acc_err) ? 32'h0000_0000 : load_data;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Load data was captured from mem_q above, so it sees the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) begin
          mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: two instances (0 and 3 wait states) checked against a
// byte-array memory model, with directed cases and randomized traffic.
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        valid0, valid3;
  logic        ready0, ready3, rv0, rv3, err0, err3;
  logic [31:0] rd0, rd3;

  int vectors = 0;
  int miscompares = 0;
  int sel = 0;
  logic [7:0] mdl [2][1024];

  always #5 clk = ~clk;

  data_mem_lsu #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid0), .req_ready(ready0),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0)
  );

  data_mem_lsu #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_ready(ready3),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(err3)
  );

  function automatic logic cur_ready();
    return (sel == 3) ? ready3 : ready0;
  endfunction

  function automatic logic cur_rv();
    return (sel == 3) ? rv3 : rv0;
  endfunction

  function automatic void clear_model();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1024; i++) mdl[s][i] = 8'h00;
  endfunction

  // Byte-level reference: legality, alignment by size, little-endian bytes, extension.
  function automatic void model_op(input logic we, input logic [2:0] f3, input logic [9:0] a,
                                   input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int s, n;
    bit legal;
    s  = (sel == 3) ? 1 : 0;
    rd = 32'h0;
    er = 1'b0;
    if (we) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    n = 1 << f3[1:0];
    if (!legal || (int'(a) % n) != 0) begin
      er = 1'b1;
      return;
    end
    if (we) begin
      for (int i = 0; i < n; i++) mdl[s][int'(a) + i] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) rd[8*i +: 8] = mdl[s][int'(a) + i];
      if (!f3[2] && n < 4 && rd[8*n-1])
        for (int i = n; i < 4; i++) rd[8*i +: 8] = 8'hFF;
    end
  endfunction

  // Runs one request on the selected instance; lat counts negedges from accept to rsp_valid.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [9:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat,
                      output logic [31:0] erd, output logic eer);
    int n;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    if (sel == 3) valid3 = 1'b1; else valid0 = 1'b1;
    n = 0;
    while (!cur_ready() && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    model_op(we, f3, a, wd, erd, eer);
    @(negedge clk);
    valid0 = 1'b0; valid3 = 1'b0;
    lat = 1;
    while (!cur_rv() && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = (sel == 3) ? rd3 : rd0;
    er = (sel == 3) ? err3 : err0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid0 = 1'b0; valid3 = 1'b0;
    req_we = 1'b0; req_funct3 = 3'd0; req_addr = 10'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    @(negedge clk);
    vectors++;
    if ({ready0, rv0, rd0, err0} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_ws0: got rdy=%b v=%b rd=%h err=%b expected rdy=1 v=0 rd=0 err=0", ready0, rv0, rd0, err0);
    end
    vectors++;
    if ({ready3, rv3, rd3, err3} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_ws3: got rdy=%b v=%b rd=%h err=%b expected rdy=1 v=0 rd=0 err=0", ready3, rv3, rd3, err3);
    end
  endtask

  task automatic test_first_load();
    logic [31:0] rd, erd; logic er, eer; int lat;
    sel = 0;
    xact(1'b0, 3'b010, 10'h000, 32'h0, rd, er, lat, erd, eer);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b0 || lat !== 2) begin
      miscompares++;
      $display("FAIL first_lw: got rd=%h err=%b lat=%0d expected rd=00000000 err=0 lat=2", rd, er, lat);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd, erd; logic er, eer; int lat;
    sel = 0;
    xact(1'b1, 3'b010, 10'h010, 32'h8000_0001, rd, er, lat, erd, eer);
    xact(1'b1, 3'b000, 10'h012, 32'h0000_00FF, rd, er, lat, erd, eer);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_rsp: got rd=%h err=%b expected rd=00000000 err=0", rd, er);
    end
    xact(1'b0, 3'b010, 10'h010, 32'h0, rd, er, lat, erd, eer);
    vectors++;
    if (rd !== 32'h80FF_0001 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_after_sb: got %h expected 80ff0001", rd);
    end
    xact(1'b0, 3'b000, 10'h012, 32'h0, rd, er, lat, erd, eer);
    vectors++;
    if (rd !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL lb_sign: got %h expected ffffffff", rd);
    end
    xact(1'b0, 3'b100, 10'h012, 32'h0, rd, er, lat, erd, eer);
    vectors++;
    if (rd !== 32'h0000_00FF) begin
      miscompares++;
      $display("FAIL lbu_zero: got %h expected 000000ff", rd);
    end
  endtask

  task automatic test_halfword();
    logic [31:0] rd, erd; logic er, eer; int lat;
    sel = 0;
    xact(1'b1, 3'b001, 10'h022, 32'h0000_8001, rd, er, lat, erd, eer);
    xact(1'b0, 3'b001, 10'h022, 32'h0, rd, er, lat, erd, eer);
    vectors++;
    if (rd !== 32'hFFFF_8001) begin
      miscompares++;
      $display("FAIL lh_sign: got %h expected ffff8001", rd);
    end
    xact(1'b0, 3'b101, 10'h022, 32'h0, rd, er, lat, erd, eer);
    vectors++;
    if (rd !== 32'h0000_8001) begin
      miscompares++;
      $display("FAIL lhu_zero: got %h expected 00008001", rd);
    end
    xact(1'b0, 3'b010, 10'h020, 32'h0, rd, er, lat, erd, eer);
    vectors++;
    if (rd !== 32'h8001_0000) begin
      miscompares++;
      $display("FAIL lw_half_upper: got %h expected 80010000", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, eer; int lat;
    sel = 0;
    xact(1'b1, 3'b010, 10'h030, 32'h1122_3344, rd, er, lat, erd, eer);
    xact(1'b0, 3'b010, 10'h031, 32'h0, rd, er, lat, erd, eer);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b1 || lat !== 2) begin
      miscompares++;
      $display("FAIL lw_misaligned: got rd=%h err=%b lat=%0d expected rd=0 err=1 lat=2", rd, er, lat);
    end
    xact(1'b1, 3'b001, 10'h033, 32'h0000_ABCD, rd, er, lat, erd, eer);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("FAIL sh_misaligned: got err=%b expected 1", er);
    end
    xact(1'b0, 3'b010, 10'h030, 32'h0, rd, er, lat, erd, eer);
    vectors++;
    if (rd !== 32'h1122_3344 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL no_write_on_err: got %h expected 11223344", rd);
    end
    xact(1'b0, 3'b011, 10'h034, 32'h0, rd, er, lat, erd, eer);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      miscompares++;
      $display("FAIL load_f3_011: got rd=%h err=%b expected rd=0 err=1", rd, er);
    end
    xact(1'b1, 3'b100, 10'h030, 32'hFFFF_FFFF, rd, er, lat, erd, eer);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("FAIL store_f3_100: got err=%b expected 1", er);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, erd; logic er, eer; int lat, low, n, extra;
    sel = 3;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 10'h050; req_wdata = 32'hCAFE_F00D;
    valid3 = 1'b1;
    n = 0;
    while (!ready3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    model_op(1'b1, 3'b010, 10'h050, 32'hCAFE_F00D, erd, eer);
    @(negedge clk);
    low = 0; extra = 0;
    while (!ready3 && low < 20) begin
      low++;
      if (rv3) extra++;
      req_we = 1'b1; req_funct3 = 3'b000;
      req_addr = 10'($urandom_range(0, 1023)); req_wdata = $urandom;
      @(negedge clk);
    end
    valid3 = 1'b0;
    vectors++;
    if (low !== 4 || extra !== 0) begin
      miscompares++;
      $display("FAIL ready_low_cycles: got %0d (early rsp %0d) expected 4 (0)", low, extra);
    end
    vectors++;
    if (rv3 !== 1'b1) begin
      miscompares++;
      $display("FAIL rsp_at_ready: got rsp_valid=%b expected 1", rv3);
    end
    @(negedge clk);
    vectors++;
    if (rv3 !== 1'b0) begin
      miscompares++;
      $display("FAIL rsp_single_pulse: got rsp_valid=%b expected 0", rv3);
    end
    xact(1'b0, 3'b010, 10'h050, 32'h0, rd, er, lat, erd, eer);
    vectors++;
    if (rd !== 32'hCAFE_F00D || er !== 1'b0 || lat !== 5) begin
      miscompares++;
      $display("FAIL ws3_readback: got rd=%h lat=%0d expected rd=cafef00d lat=5", rd, lat);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd, erd; logic er, eer; int lat, n, seen;
    sel = 3;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 10'h040; req_wdata = 32'hDEAD_BEEF;
    valid3 = 1'b1;
    n = 0;
    while (!ready3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    valid3 = 1'b0;
    #2 rst_n = 1'b0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (rv3) seen++;
    end
    rst_n = 1'b1;
    clear_model();
    repeat (6) begin
      @(negedge clk);
      if (rv3) seen++;
    end
    vectors++;
    if (seen !== 0 || ready3 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_midop: got rsp pulses=%0d ready=%b expected 0 and 1", seen, ready3);
    end
    xact(1'b0, 3'b010, 10'h040, 32'h0, rd, er, lat, erd, eer);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_discards_write: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_random(input int which, input int count);
    logic [31:0] rd, erd, wd; logic er, eer, we; logic [2:0] f3; logic [9:0] a; int lat;
    sel = which;
    for (int i = 0; i < count; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 63));
      wd = $urandom;
      xact(we, f3, a, wd, rd, er, lat, erd, eer);
      vectors++;
      if (rd !== erd || er !== eer || lat !== 2 + which) begin
        miscompares++;
        $display("FAIL random_ws%0d: we=%b f3=%b a=%h got rd=%h err=%b lat=%0d expected rd=%h err=%b lat=%0d",
                 which, we, f3, a, rd, er, lat, erd, eer, 2 + which);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_byte_lanes();
    test_halfword();
    test_errors();
    test_wait_states();
    test_reset_midop();
    test_random(0, 150);
    test_random(3, 120);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Byte-addressable, little-endian data memory for the RV32 pipeline's MEM stage, replacing the word-only memory. Supports all RV32I load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane write masking and load sign/zero extension. A valid/ready request channel and a fixed, parameterised wait-state count let the hazard unit stall on `req_ready`/`rsp_valid`. Misaligned or illegal accesses are flagged, not executed.

## Interface
- `ADDR_WIDTH`, 10: byte-address width; depth = 2^(ADDR_WIDTH-2) 32-bit words.
- `WAIT_STATES`, 0: extra cycles between accept and response; legal range 0..15.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 width code.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: load result, already extended; 0 for stores and errors.
- `rsp_err` out 1: misaligned or illegal access; qualified by `rsp_valid`.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `req_ready`=1. On `req_valid`, latch we/funct3/addr/wdata and load the wait counter with `WAIT_STATES`. If `WAIT_STATES`=0, go to RESP; otherwise go to WAIT.
  - WAIT: decrement the counter each cycle; go to RESP when the counter reaches 1.
  - RESP: commit the access, drive `rsp_valid`=1 for exactly one cycle, return to IDLE.
- `req_ready`=0 in WAIT and RESP. Only one request is outstanding at a time.
- There is no response backpressure; the consumer must sample on `rsp_valid`.
- Word index = addr[ADDR_WIDTH-1:2]. Byte lane = addr[1:0]; lane 0 = bits 7:0.
- Stores:
  - SB (000): write lane addr[1:0] with wdata[7:0].
  - SH (001): write lanes addr[1]*2 and addr[1]*2+1 with wdata[15:0].
  - SW (010): write all four lanes.
  - Unwritten lanes keep their value.
- Loads:
  - LB (000): sign-extend the selected byte.
  - LH (001): sign-extend the selected halfword.
  - LW (010): full word.
  - LBU (100): zero-extend the selected byte.
  - LHU (101): zero-extend the selected halfword.
- Error conditions:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Load funct3 ∈ {011,110,111}.
  - Store funct3 ∉ {000,001,010}.
- On error: no memory change, `rsp_rdata`=0, `rsp_err`=1, and the handshake completes normally.
- Load data reflects memory at the RESP cycle, before any write committed in that same cycle. Only one access exists per cycle, so there is no collision.

## Timing
- Reset (async assert, sync release by clk edge):
  - FSM = IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - All memory words cleared to 0.
- Latency: a request accepted on edge N gives `rsp_valid` high in the cycle after edge N+1+`WAIT_STATES`.
  - Store data is visible to a load accepted on any later edge.
- Throughput: one request per 2+`WAIT_STATES` cycles. `req_ready` returns to 1 in the cycle after the RESP pulse.
- `rsp_rdata` and `rsp_err` are registered and held until the next response, except that they are cleared by reset.
- Reset mid-operation (WAIT or RESP): the in-flight request is discarded, no write is committed, and no `rsp_valid` is produced.
- `req_*` inputs are ignored while `req_ready`=0.
- Address wrap: all ADDR_WIDTH bits index the memory; there is no out-of-range case.

## Test plan
- Reset then LW at 0x000 with `WAIT_STATES`=0 -> `rsp_valid` 2 cycles after accept, `rsp_rdata`=0x00000000, `rsp_err`=0.
- SW 0x80000001 @0x010, then SB 0xFF @0x012, then LW @0x010 -> 0x80FF0001. Then LB @0x012 -> 0xFFFFFFFF, and LBU @0x012 -> 0x000000FF.
- SH 0x8001 @0x022, then LH @0x022 -> 0xFFFF8001, LHU @0x022 -> 0x00008001, LW @0x020 -> 0x80010000.
- Misaligned accesses:
  - LW @0x031 -> `rsp_err`=1, `rsp_rdata`=0.
  - SH @0x033 -> `rsp_err`=1, and a later LW @0x030 returns the unchanged value.
  - Load with funct3=011 -> `rsp_err`=1.
- `WAIT_STATES`=3:
  - With `req_valid` held high, `req_ready` low for exactly 4 cycles after accept.
  - `rsp_valid` pulses once, 5 cycles after the accept edge.
  - Inputs changed during WAIT have no effect.
- Assert `rst_n` low during WAIT of a SW 0xDEADBEEF @0x040 -> no `rsp_valid`. After release, LW @0x040 -> 0x00000000 and `req_ready`=1.
